// File: rtl/freq_div_ctrl.sv
// Runtime-programmable 50 % duty clock divider (N >= 2, odd or even) with
// glitch-free ratio updates at period boundaries and clean start/stop from an enable.
module freq_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             i_clk_in,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic             i_cfg_valid,
    input  logic [CNT_W-1:0] i_cfg_div,
    output logic             o_cfg_ready,
    output logic             o_cfg_err,
    output logic             o_clk_out,
    output logic             o_busy,
    output logic             o_wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_pend_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_en;
    logic             r_p;
    logic             r_n;
    logic             r_err;
    logic             w_p_nxt;
    logic             w_accept;
    logic             w_legal;
    logic             w_at_wrap;
    logic             w_ready;

    assign w_ready   = (r_state != S_PEND);
    assign w_accept  = i_cfg_valid && w_ready;
    assign w_legal   = (i_cfg_div >= TWO);
    assign w_at_wrap = (r_cnt == (r_div - ONE));

    // State register. The enable is registered first, so the divided clock
    // starts one cycle after the edge that samples i_en.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk_in or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= i_en;
        end
    end

    // Next-state logic.
    // NOTE: defaults at the top of each combinational block keep every path
    // assigned, so no latches are inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_en) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_at_wrap && !r_en)          w_state_nxt = S_IDLE;
                else if (w_accept && w_legal)    w_state_nxt = S_PEND;
            end
            S_PEND: begin
                if (w_at_wrap) w_state_nxt = r_en ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath next values: ratio, pending ratio, period counter, phase.
    always_comb begin
        w_div_nxt  = r_div;
        w_pend_nxt = r_pend_div;
        w_cnt_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_legal) w_div_nxt = i_cfg_div;
            end
            S_RUN: begin
                // A request that lands on the final wrap before stopping is
                // loaded directly, as it would be after a PEND->IDLE exit.
                if (w_accept && w_legal) begin
                    if (w_at_wrap && !r_en) w_div_nxt  = i_cfg_div;
                    else                    w_pend_nxt = i_cfg_div;
                end
                w_cnt_nxt = w_at_wrap ? '0 : (r_cnt + ONE);
            end
            S_PEND: begin
                if (w_at_wrap) w_div_nxt = r_pend_div;
                w_cnt_nxt = w_at_wrap ? '0 : (r_cnt + ONE);
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
        // floor(N/2) serves both parities: the odd half-cycle comes from r_n.
        w_p_nxt = (w_state_nxt != S_IDLE) && (w_cnt_nxt < (w_div_nxt >> 1));
    end

    always_ff @(posedge i_clk_in or negedge i_rstn) begin
        if (!i_rstn) begin
            r_div      <= DIV_RST;
            r_pend_div <= DIV_RST;
            r_cnt      <= '0;
            r_p        <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_div      <= w_div_nxt;
            r_pend_div <= w_pend_nxt;
            r_cnt      <= w_cnt_nxt;
            r_p        <= w_p_nxt;
            r_err      <= w_accept && !w_legal;
        end
    end

    // Half-cycle extension of the high phase for odd ratios.
    always_ff @(negedge i_clk_in or negedge i_rstn) begin
        if (!i_rstn) r_n <= 1'b0;
        else         r_n <= r_p;
    end

    // Outputs.
    always_comb begin
        o_cfg_ready = w_ready;
        o_busy      = (r_state != S_IDLE);
        o_wrap      = (r_state != S_IDLE) && w_at_wrap;
        o_cfg_err   = r_err;
        o_clk_out   = r_p | (r_n & r_div[0]);
    end

endmodule
